// File: rtl/fix_checksum_gen.sv
// FIX tag-10 CheckSum: mod-256 byte sum converted to three ASCII digits.
// Optional FIX_BODYLEN_EN adds a saturating body-length count on body_len_o.
module fix_checksum_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  byte_ready_o,
  output logic                  digit_valid_o,
  output logic [7:0]            digit_o,
  output logic                  digit_last_o,
  input  logic                  digit_ready_i,
  output logic [7:0]            sum_o,
`ifdef FIX_BODYLEN_EN
  output logic [LEN_WIDTH-1:0]  body_len_o,
`endif
  output logic                  busy_o
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("fix_checksum_gen: DATA_WIDTH must be 8");
  end
  if (LEN_WIDTH < 1) begin : g_bad_len
    $error("fix_checksum_gen: LEN_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, ACC, CONV_H, CONV_T, OUT_H, OUT_T, OUT_U
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] sum_q, sum_d;
  logic [1:0] h_q, h_d;
  logic [3:0] t_q, t_d;
  logic [3:0] u_q, u_d;
  logic [7:0] digit_q, digit_d;
  logic       dvalid_q, dvalid_d;
  logic       dlast_q, dlast_d;

  logic       accept;
  logic       take;
  logic [7:0] acc_nxt;

  // Ready is masked by rst so every output reads 0 while reset is held.
  assign byte_ready_o = ~rst & ((state_q == IDLE) | (state_q == ACC));
  assign accept  = byte_valid_i & byte_ready_o;
  assign take    = dvalid_q & digit_ready_i;
  assign acc_nxt = start_i ? byte_i : acc_q + byte_i;

`ifdef FIX_BODYLEN_EN
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] blen_q, blen_d;
  logic [LEN_WIDTH-1:0] len_nxt;

  always_comb begin
    len_nxt = len_q;
    if (start_i) begin
      len_nxt = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    end else if (len_q != {LEN_WIDTH{1'b1}}) begin
      len_nxt = len_q + 1'b1;
    end
  end

  always_comb begin
    len_d  = len_q;
    blen_d = blen_q;
    if (accept && (start_i || state_q == ACC)) begin
      len_d = len_nxt;
      if (stop_i) blen_d = len_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= '0;
      blen_q <= '0;
    end else begin
      len_q  <= len_d;
      blen_q <= blen_d;
    end
  end

  assign body_len_o = blen_q;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    h_d      = h_q;
    t_d      = t_q;
    u_d      = u_q;
    digit_d  = digit_q;
    dvalid_d = dvalid_q;
    dlast_d  = dlast_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (accept && (start_i || state_q == ACC)) begin
          acc_d   = acc_nxt;
          state_d = ACC;
          if (stop_i) begin
            rem_d   = acc_nxt;
            sum_d   = acc_nxt;
            state_d = CONV_H;
          end
        end
      end
      CONV_H: begin
        if (rem_q >= 8'd100) begin
          rem_d = rem_q - 8'd100;
          h_d   = h_q + 2'd1;
        end else begin
          state_d = CONV_T;
        end
      end
      CONV_T: begin
        if (rem_q >= 8'd10) begin
          rem_d = rem_q - 8'd10;
          t_d   = t_q + 4'd1;
        end else begin
          u_d      = rem_q[3:0];
          state_d  = OUT_H;
          digit_d  = 8'h30 + {6'd0, h_q};
          dvalid_d = 1'b1;
        end
      end
      OUT_H: begin
        if (take) begin
          state_d = OUT_T;
          digit_d = 8'h30 + {4'd0, t_q};
        end
      end
      OUT_T: begin
        if (take) begin
          state_d = OUT_U;
          digit_d = 8'h30 + {4'd0, u_q};
          dlast_d = 1'b1;
        end
      end
      OUT_U: begin
        if (take) begin
          state_d  = IDLE;
          h_d      = '0;
          t_d      = '0;
          u_d      = '0;
          digit_d  = '0;
          dvalid_d = 1'b0;
          dlast_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      sum_q    <= '0;
      h_q      <= '0;
      t_q      <= '0;
      u_q      <= '0;
      digit_q  <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sum_q    <= sum_d;
      h_q      <= h_d;
      t_q      <= t_d;
      u_q      <= u_d;
      digit_q  <= digit_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
    end
  end

  assign digit_o       = digit_q;
  assign digit_valid_o = dvalid_q;
  assign digit_last_o  = dlast_q;
  assign sum_o         = sum_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_fix_checksum_gen.sv
// Directed-vector bench for fix_checksum_gen.
// Expected sums and digits are hand-computed per scenario.
module tb_fix_checksum_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       byte_ready_o;
  logic       digit_valid_o;
  logic [7:0] digit_o;
  logic       digit_last_o;
  logic       digit_ready_i = 1'b0;
  logic [7:0] sum_o;
  logic       busy_o;
`ifdef FIX_BODYLEN_EN
  logic [15:0] body_len_o;
`endif

  int total = 0;
  int bad = 0;

  fix_checksum_gen dut (
    .clk           (clk),
    .rst           (rst),
    .byte_valid_i  (byte_valid_i),
    .byte_i        (byte_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .byte_ready_o  (byte_ready_o),
    .digit_valid_o (digit_valid_o),
    .digit_o       (digit_o),
    .digit_last_o  (digit_last_o),
    .digit_ready_i (digit_ready_i),
    .sum_o         (sum_o),
`ifdef FIX_BODYLEN_EN
    .body_len_o    (body_len_o),
`endif
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b,
                      input logic st,
                      input logic sp);
    byte_i = b;
    start_i = st;
    stop_i = sp;
    byte_valid_i = 1'b1;
    tick();
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!digit_valid_o && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic grab(output logic [23:0] d,
                      output logic [2:0] l,
                      output logic [2:0] v);
    for (int i = 2; i >= 0; i--) begin
      d[i*8 +: 8] = digit_o;
      l[i] = digit_last_o;
      v[i] = digit_valid_o;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (digit_valid_o !== 1'b0 || digit_o !== 8'h00 ||
        digit_last_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_digit got v=%b d=%h l=%b exp 0 0 0",
               digit_valid_o, digit_o, digit_last_o);
    end
    total++;
    if (sum_o !== 8'h00 || busy_o !== 1'b0 ||
        byte_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_misc got sum=%h busy=%b rdy=%b exp 0 0 0",
               sum_o, busy_o, byte_ready_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if (byte_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready got=%b exp=1", byte_ready_o);
    end
  endtask

  task automatic test_ignored();
    send(8'h99, 1'b0, 1'b0);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_nostart got busy=%b exp=0", busy_o);
    end
    start_i = 1'b1;
    stop_i = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL start_novalid got busy=%b exp=0", busy_o);
    end
  endtask

  task automatic test_basic();
    int n;
    logic [23:0] d;
    logic [2:0] l, v;
    digit_ready_i = 1'b1;
    send(8'h41, 1'b1, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b1);
    total++;
    if (byte_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_conv got rdy=%b busy=%b exp 0 1",
               byte_ready_o, busy_o);
    end
    wait_out(n);
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL basic_latency got=%0d exp=6", n);
    end
    total++;
    if (sum_o !== 8'h84) begin
      bad++;
      $display("FAIL basic_sum got=%h exp=84", sum_o);
    end
    grab(d, l, v);
    total++;
    if (d !== 24'h313332 || l !== 3'b001 || v !== 3'b111) begin
      bad++;
      $display("FAIL basic_digits got d=%h l=%b v=%b exp 313332 001 111",
               d, l, v);
    end
    total++;
    if (digit_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_end got v=%b busy=%b exp 0 0",
               digit_valid_o, busy_o);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [23:0] d;
    logic [2:0] l, v;
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    wait_out(n);
    total++;
    if (n != 9 || sum_o !== 8'hFD) begin
      bad++;
      $display("FAIL wrap_sum got n=%0d sum=%h exp 9 fd", n, sum_o);
    end
    grab(d, l, v);
    total++;
    if (d !== 24'h323533 || l !== 3'b001 || v !== 3'b111) begin
      bad++;
      $display("FAIL wrap_digits got d=%h l=%b v=%b exp 323533 001 111",
               d, l, v);
    end
  endtask

  task automatic test_zero();
    int n;
    logic [23:0] d;
    logic [2:0] l, v;
    send(8'h00, 1'b1, 1'b1);
    wait_out(n);
    total++;
    if (n != 2 || sum_o !== 8'h00) begin
      bad++;
      $display("FAIL zero_sum got n=%0d sum=%h exp 2 00", n, sum_o);
    end
`ifdef FIX_BODYLEN_EN
    total++;
    if (body_len_o !== 16'd1) begin
      bad++;
      $display("FAIL zero_len got=%0d exp=1", body_len_o);
    end
`endif
    grab(d, l, v);
    total++;
    if (d !== 24'h303030 || l !== 3'b001 || v !== 3'b111) begin
      bad++;
      $display("FAIL zero_digits got d=%h l=%b v=%b exp 303030 001 111",
               d, l, v);
    end
  endtask

  task automatic test_stall();
    int n;
    int errs;
    send(8'h41, 1'b1, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b1);
    wait_out(n);
    total++;
    if (digit_o !== 8'h31) begin
      bad++;
      $display("FAIL stall_first got=%h exp=31", digit_o);
    end
    tick();
    digit_ready_i = 1'b0;
    byte_i = 8'h77;
    start_i = 1'b1;
    byte_valid_i = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (digit_o !== 8'h33 || digit_valid_o !== 1'b1 ||
          digit_last_o !== 1'b0 || byte_ready_o !== 1'b0)
        errs++;
      tick();
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold got %0d bad cycles exp 0", errs);
    end
    total++;
    if (digit_o !== 8'h33 || digit_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_after got d=%h v=%b exp 33 1",
               digit_o, digit_valid_o);
    end
    digit_ready_i = 1'b1;
    tick();
    total++;
    if (digit_o !== 8'h32 || digit_last_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_units got d=%h l=%b exp 32 1",
               digit_o, digit_last_o);
    end
    tick();
    total++;
    if (digit_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        sum_o !== 8'h84) begin
      bad++;
      $display("FAIL stall_end got v=%b busy=%b sum=%h exp 0 0 84",
               digit_valid_o, busy_o, sum_o);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    logic [23:0] d;
    logic [2:0] l, v;
    send(8'h41, 1'b1, 1'b1);
    wait_out(n);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (digit_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_out got %0d active cycles exp 0", seen);
    end
    send(8'h30, 1'b1, 1'b0);
    send(8'h40, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy_o !== 1'b0 || sum_o !== 8'h00) begin
      bad++;
      $display("FAIL abort_acc got busy=%b sum=%h exp 0 00",
               busy_o, sum_o);
    end
    send(8'h10, 1'b1, 1'b0);
    send(8'h05, 1'b0, 1'b1);
    wait_out(n);
    total++;
    if (n != 4 || sum_o !== 8'h15) begin
      bad++;
      $display("FAIL abort_sum got n=%0d sum=%h exp 4 15", n, sum_o);
    end
    grab(d, l, v);
    total++;
    if (d !== 24'h303231 || l !== 3'b001 || v !== 3'b111) begin
      bad++;
      $display("FAIL abort_digits got d=%h l=%b v=%b exp 303231 001 111",
               d, l, v);
    end
  endtask

  task automatic test_restart();
    int n;
    logic [23:0] d;
    logic [2:0] l, v;
    send(8'h50, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b1);
    wait_out(n);
    total++;
    if (n != 5 || sum_o !== 8'h21) begin
      bad++;
      $display("FAIL restart_sum got n=%0d sum=%h exp 5 21", n, sum_o);
    end
`ifdef FIX_BODYLEN_EN
    total++;
    if (body_len_o !== 16'd2) begin
      bad++;
      $display("FAIL restart_len got=%0d exp=2", body_len_o);
    end
`endif
    grab(d, l, v);
    total++;
    if (d !== 24'h303333 || l !== 3'b001 || v !== 3'b111) begin
      bad++;
      $display("FAIL restart_digits got d=%h l=%b v=%b exp 303333 001 111",
               d, l, v);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ignored();
    test_basic();
    test_wrap();
    test_zero();
    test_stall();
    test_reset_abort();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_checksum_gen.md
Name: fix_checksum_gen

Overview:
- Downstream consumer of the FIX message-serializer byte stream.
- Accumulates the FIX CheckSum (tag 10): the sum of all message bytes, modulo 256, from message start through the SOH that precedes "10=".
- Converts the sum to three ASCII decimal digits and returns them over a valid/ready handshake so the serializer can emit them after "10=".
- Has real sequential content: accumulator, iterative binary-to-decimal FSM, output handshake.

Parameters:
- DATA_WIDTH, 8, width of the byte stream. Fixed at 8; any other value is a synthesis-time error.
- LEN_WIDTH, 16, width of the body-length counter. Used only with FIX_BODYLEN_EN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- byte_valid_i  input  1  byte_i is valid this cycle
- byte_i  input  8  serialized message byte
- start_i  input  1  qualifies the first byte of a message; sampled only when byte_valid_i=1
- stop_i  input  1  qualifies the last byte included in the checksum; sampled only when byte_valid_i=1
- byte_ready_o  output  1  block accepts bytes; high only in IDLE and ACC
- digit_valid_o  output  1  digit_o holds a valid ASCII digit
- digit_o  output  8  ASCII digit, 0x30..0x39
- digit_last_o  output  1  high with the units digit
- digit_ready_i  input  1  consumer takes digit_o on a cycle where valid and ready are both high
- sum_o  output  8  final mod-256 sum; held from stop until the next start
- busy_o  output  1  high in every state except IDLE
- body_len_o  output  LEN_WIDTH  byte count; present only with FIX_BODYLEN_EN

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulator, remainder and digit registers cleared.
- A byte is accepted on a clock edge when byte_valid_i=1 and byte_ready_o=1.

State machine:
- IDLE
  - Accepted byte with start_i=1: acc <= byte_i, go to ACC.
  - Accepted byte with start_i=0: ignored.
  - Accepted byte with start_i=1 and stop_i=1 (one-byte message): acc <= byte_i, go directly to CONV_H.
- ACC
  - Each accepted byte: acc <= acc + byte_i, truncated to 8 bits (wrap-around required).
  - stop_i with an accepted byte: that byte is included; latch the result into rem and sum_o; go to CONV_H.
  - start_i without stop_i: restart, acc <= byte_i, stay in ACC.
  - Cycles with byte_valid_i=0: no change.
- CONV_H (one cycle per iteration)
  - rem >= 100: rem <= rem - 100, h <= h + 1.
  - Otherwise: go to CONV_T.
- CONV_T (one cycle per iteration)
  - rem >= 10: rem <= rem - 10, t <= t + 1.
  - Otherwise: u <= rem, go to OUT_H.
- OUT_H: digit_o = 0x30 + h, digit_valid_o = 1. On handshake, go to OUT_T.
- OUT_T: digit_o = 0x30 + t, digit_valid_o = 1. On handshake, go to OUT_U.
- OUT_U: digit_o = 0x30 + u, digit_valid_o = 1, digit_last_o = 1. On handshake, clear h/t/u and go to IDLE.

Timing and conversion:
- Conversion occupies exactly h + t + 2 cycles; maximum 9 cycles, for sum 255.
- Example: stop accepted at edge E with sum 132 → OUT_H entered 6 cycles after E.
- Registered outputs: digit_o, digit_valid_o and digit_last_o must not change while valid=1 and ready=0.

Boundary conditions:
- byte_ready_o=0 in CONV_*/OUT_*; bytes offered there are dropped, and the upstream must stall.
- start_i or stop_i with byte_valid_i=0 are ignored.
- rst in any state returns the block to IDLE on the next edge. A partially output digit sequence is abandoned; no further digits appear.
- A sum of 0 produces "000"; leading zeros are always emitted (three digits exactly).

Optional Feature:
- Macro: FIX_BODYLEN_EN.
- Defined:
  - Adds body_len_o and a LEN_WIDTH counter.
  - Start byte sets the counter to 1; each further accepted byte in ACC increments it, saturating at all-ones.
  - The value is latched to body_len_o at stop and held until the next start.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bytes 0x41(start), 0x42, 0x01(stop), digit_ready_i=1 → sum_o=0x84; digits 0x31, 0x33, 0x32 on consecutive cycles, last flag on 0x32; OUT_H entered 6 cycles after stop.
- Bytes 0xFF(start), 0xFF, 0xFF(stop) → wrap, sum_o=0xFD; digits 0x32, 0x35, 0x33.
- Single byte 0x00 with start=stop=1 → "000" (0x30, 0x30, 0x30); with FIX_BODYLEN_EN, body_len_o=1.
- Sum 0x84, digit_ready_i low for 5 cycles in OUT_T → digit_o held at 0x33 with valid high throughout; no digit lost or duplicated; byte_ready_o=0 and bytes offered during this time are dropped.
- rst asserted in ACC after 2 bytes, then new message 0x10(start), 0x05(stop) → sum_o=0x15; digits 0x30, 0x32, 0x31; no residue from the aborted message.
- Second start mid-ACC: 0x50(start), 0x20(start), 0x01(stop) → sum_o=0x21; digits "033"; with FIX_BODYLEN_EN, body_len_o=2.
